// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage and the memory: request/write payload out, read word and ack back.
interface mem_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wr_data,
        input  bus_rd_data, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wr_data,
        output bus_rd_data, bus_ack
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, aligns load data and owns the MEM/WB register.
module mem_stage #(
    parameter int unsigned MEM_OP_W = 4
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic                stall,
    input  logic                flush,
    input  logic                ex_en,
    input  logic [MEM_OP_W-1:0] ex_mem_op,
    input  logic [31:0]         ex_mem_wr_data,
    input  logic [4:0]          ex_dst_addr,
    input  logic                ex_gpr_we_,
    input  logic [31:0]         ex_out,
    mem_stage_if.master         bus,
    output logic                mem_busy,
    output logic                mem_en,
    output logic [4:0]          mem_dst_addr,
    output logic                mem_gpr_we_,
    output logic [31:0]         mem_out,
    output logic                mem_miss_align
);
    localparam logic [MEM_OP_W-1:0] OP_LB  = MEM_OP_W'(1);
    localparam logic [MEM_OP_W-1:0] OP_LBU = MEM_OP_W'(2);
    localparam logic [MEM_OP_W-1:0] OP_LH  = MEM_OP_W'(3);
    localparam logic [MEM_OP_W-1:0] OP_LHU = MEM_OP_W'(4);
    localparam logic [MEM_OP_W-1:0] OP_LW  = MEM_OP_W'(5);
    localparam logic [MEM_OP_W-1:0] OP_SB  = MEM_OP_W'(6);
    localparam logic [MEM_OP_W-1:0] OP_SH  = MEM_OP_W'(7);
    localparam logic [MEM_OP_W-1:0] OP_SW  = MEM_OP_W'(8);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  dst;
        logic        we_;
        logic [31:0] out;
        logic        miss;
    } wb_t;

    localparam wb_t WB_BUBBLE = '{en: 1'b0, dst: 5'd0, we_: 1'b1, out: 32'd0, miss: 1'b0};

    state_t              state;
    logic                discard;
    wb_t                 wb;
    wb_t                 wb_buf;
    logic                bus_req_r, bus_we_r;
    logic [31:0]         bus_addr_r, bus_wr_data_r;
    logic [3:0]          bus_be_r;
    logic [MEM_OP_W-1:0] lat_op;
    logic [1:0]          lat_lo;
    logic [4:0]          lat_dst;
    logic                lat_we_;
    logic [31:0]         lat_out;

    logic                is_load, is_store, misalign, is_mem, launch;
    logic [3:0]          st_be;
    logic [31:0]         st_data;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [31:0]         ld_data;
    wb_t                 result;

    // Decode the EX/MEM op: class, alignment and store lane steering
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        st_be    = 4'b0000;
        st_data  = 32'd0;
        case (ex_mem_op)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load  = 1'b1;
                misalign = ex_out[0];
            end
            OP_LW: begin
                is_load  = 1'b1;
                misalign = |ex_out[1:0];
            end
            OP_SB: begin
                is_store = 1'b1;
                st_be    = 4'b0001 << ex_out[1:0];
                st_data  = {4{ex_mem_wr_data[7:0]}};
            end
            OP_SH: begin
                is_store = 1'b1;
                misalign = ex_out[0];
                st_be    = ex_out[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{ex_mem_wr_data[15:0]}};
            end
            OP_SW: begin
                is_store = 1'b1;
                misalign = |ex_out[1:0];
                st_be    = 4'b1111;
                st_data  = ex_mem_wr_data;
            end
            default: ;
        endcase
        is_mem = is_load | is_store;
        launch = ex_en & is_mem & ~misalign;
    end

    // Little-endian lane extraction of the returned word
    always_comb begin
        ld_byte = 8'(bus.bus_rd_data >> {lat_lo, 3'b000});
        ld_half = lat_lo[1] ? bus.bus_rd_data[31:16] : bus.bus_rd_data[15:0];
        case (lat_op)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = bus.bus_rd_data;
        endcase
        result.en   = 1'b1;
        result.dst  = lat_dst;
        result.miss = 1'b0;
        if (lat_op inside {OP_SB, OP_SH, OP_SW}) begin
            result.we_ = 1'b1;
            result.out = lat_out;
        end else begin
            result.we_ = lat_we_;
            result.out = ld_data;
        end
    end

    always_comb begin
        mem_busy = 1'b0;
        case (state)
            IDLE:    mem_busy = launch;
            REQ:     mem_busy = ~bus.bus_ack;
            default: mem_busy = 1'b0;
        endcase
    end

    // FSM, bus request registers and MEM/WB register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state         <= IDLE;
            discard       <= 1'b0;
            wb            <= WB_BUBBLE;
            wb_buf        <= WB_BUBBLE;
            bus_req_r     <= 1'b0;
            bus_we_r      <= 1'b0;
            bus_addr_r    <= 32'd0;
            bus_be_r      <= 4'b0000;
            bus_wr_data_r <= 32'd0;
            lat_op        <= '0;
            lat_lo        <= 2'b00;
            lat_dst       <= 5'd0;
            lat_we_       <= 1'b1;
            lat_out       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch && !(flush && !stall)) begin
                        state         <= REQ;
                        bus_req_r     <= 1'b1;
                        bus_we_r      <= is_store;
                        bus_addr_r    <= {ex_out[31:2], 2'b00};
                        bus_be_r      <= is_store ? st_be : 4'b1111;
                        bus_wr_data_r <= st_data;
                        lat_op        <= ex_mem_op;
                        lat_lo        <= ex_out[1:0];
                        lat_dst       <= ex_dst_addr;
                        lat_we_       <= ex_gpr_we_;
                        lat_out       <= ex_out;
                        if (!stall) wb <= WB_BUBBLE;
                    end else if (!stall) begin
                        if (flush)
                            wb <= WB_BUBBLE;
                        else if (ex_en && is_mem)
                            wb <= '{en: 1'b1, dst: ex_dst_addr, we_: 1'b1, out: ex_out, miss: 1'b1};
                        else
                            wb <= '{en: ex_en, dst: ex_dst_addr, we_: ex_gpr_we_, out: ex_out, miss: 1'b0};
                    end
                end
                REQ: begin
                    if (flush) discard <= 1'b1;
                    if (bus.bus_ack) begin
                        bus_req_r <= 1'b0;
                        discard   <= 1'b0;
                        if (!stall) begin
                            wb    <= (discard || flush) ? WB_BUBBLE : result;
                            state <= IDLE;
                        end else begin
                            wb_buf <= (discard || flush) ? WB_BUBBLE : result;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!stall) begin
                        wb    <= flush ? WB_BUBBLE : wb_buf;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_req     = bus_req_r;
    assign bus.bus_we      = bus_we_r;
    assign bus.bus_addr    = bus_addr_r;
    assign bus.bus_be      = bus_be_r;
    assign bus.bus_wr_data = bus_wr_data_r;

    assign mem_en         = wb.en;
    assign mem_dst_addr   = wb.dst;
    assign mem_gpr_we_    = wb.we_;
    assign mem_out        = wb.out;
    assign mem_miss_align = wb.miss;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected MEM/WB entries, a monitor checks each change.
module tb_mem_stage;
    localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4;
    localparam logic [3:0] LW = 4'd5, SB = 4'd6, SH = 4'd7;

    logic        clk = 1'b0;
    logic        reset_, stall, flush, xstall;
    logic        ex_en, ex_gpr_we_;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic        mem_busy, mem_en, mem_gpr_we_, mem_miss_align;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_out;

    mem_stage_if bif ();

    mem_stage dut (
        .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .ex_en(ex_en),
        .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_out(ex_out), .bus(bif), .mem_busy(mem_busy),
        .mem_en(mem_en), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
        .mem_out(mem_out), .mem_miss_align(mem_miss_align)
    );

    always #5 clk = ~clk;

    // Pipeline control: stall whenever the MEM stage asks, plus bench-forced stall
    assign stall = mem_busy | xstall;

    int          checks = 0;
    int          failures = 0;
    logic [39:0] exp_q[$];
    int          busy_cnt = 0;
    int          req_cycles = 0;
    int          ack_wait = 0;
    logic [31:0] rd_word = 32'd0;
    logic [31:0] cap_addr = 32'd0, cap_wr = 32'd0;
    logic [3:0]  cap_be = 4'd0;
    logic        cap_we = 1'b0;

    assign bif.bus_rd_data = rd_word;

    function automatic logic [39:0] wbv(input logic en, input logic [4:0] dst, input logic we_n,
                                        input logic [31:0] out, input logic miss);
        return {en, dst, we_n, out, miss};
    endfunction

    localparam logic [39:0] BUBBLE = {1'b0, 5'd0, 1'b1, 32'd0, 1'b0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Memory responder: acks after ack_wait REQ cycles
    initial begin
        int wcnt;
        wcnt = 0;
        bif.bus_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bif.bus_ack = 1'b0;
            if (reset_ && bif.bus_req) begin
                if (wcnt >= ack_wait) begin
                    bif.bus_ack = 1'b1;
                    wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    // Observers: busy cycles, request cycles and the last request payload
    initial begin
        forever begin
            @(negedge clk);
            if (mem_busy) busy_cnt++;
            if (bif.bus_req) begin
                req_cycles++;
                cap_addr = bif.bus_addr;
                cap_be   = bif.bus_be;
                cap_wr   = bif.bus_wr_data;
                cap_we   = bif.bus_we;
            end
        end
    end

    // Scoreboard monitor: every change of the MEM/WB register is checked against the queue
    initial begin
        logic [39:0] last, cur, e;
        last = BUBBLE;
        forever begin
            @(negedge clk);
            cur = {mem_en, mem_dst_addr, mem_gpr_we_, mem_out, mem_miss_align};
            if (cur !== last) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wb_unexpected act=%h", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL wb_entry act en=%b dst=%0d we_=%b out=%h miss=%b exp en=%b dst=%0d we_=%b out=%h miss=%b",
                                 cur[39], cur[38:34], cur[33], cur[32:1], cur[0],
                                 e[39], e[38:34], e[33], e[32:1], e[0]);
                    end
                end
                last = cur;
            end
        end
    end

    task automatic set_ex(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] dst, input logic we_n);
        ex_en = 1'b1; ex_mem_op = op; ex_out = addr; ex_mem_wr_data = data;
        ex_dst_addr = dst; ex_gpr_we_ = we_n;
    endtask

    // Hold the op until an edge where the pipeline is not stalled
    task automatic wait_accept(input string nm);
        int   n;
        logic s;
        n = 0;
        do begin
            @(negedge clk);
            s = stall;
            @(posedge clk);
            #1;
            n++;
        end while (s && n < 60);
        if (s) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout act=stalled exp=accepted", nm);
        end
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] dst, input logic we_n);
        busy_cnt = 0;
        req_cycles = 0;
        set_ex(op, addr, data, dst, we_n);
        wait_accept(nm);
    endtask

    initial begin
        reset_ = 1'b0; xstall = 1'b0; flush = 1'b0;
        ex_en = 1'b0; ex_mem_op = NOP; ex_out = 32'd0; ex_mem_wr_data = 32'd0;
        ex_dst_addr = 5'd0; ex_gpr_we_ = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_gpr_we", 32'(mem_gpr_we_), 32'd1);
        chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
        chk("rst_bus_addr", bif.bus_addr, 32'd0);
        chk("rst_busy", 32'(mem_busy), 32'd0);
        reset_ = 1'b1;

        exp_q.push_back(wbv(1'b1, 5'd3, 1'b0, 32'h1234, 1'b0));
        issue("add", NOP, 32'h1234, 32'd0, 5'd3, 1'b0);
        chk("add_busy", 32'(busy_cnt), 32'd0);

        ack_wait = 2; rd_word = 32'h80FF_FFFF;
        exp_q.push_back(wbv(1'b1, 5'd5, 1'b0, 32'hFFFF_FF80, 1'b0));
        issue("lb", LB, 32'h103, 32'd0, 5'd5, 1'b0);
        chk("lb_busy", 32'(busy_cnt), 32'd3);
        chk("lb_addr", cap_addr, 32'h100);
        chk("lb_req_cycles", 32'(req_cycles), 32'd3);

        ack_wait = 0;
        exp_q.push_back(wbv(1'b1, 5'd6, 1'b0, 32'h0000_0080, 1'b0));
        issue("lbu", LBU, 32'h103, 32'd0, 5'd6, 1'b0);
        chk("lbu_busy", 32'(busy_cnt), 32'd1);

        exp_q.push_back(wbv(1'b1, 5'd7, 1'b1, 32'h202, 1'b0));
        issue("sh", SH, 32'h202, 32'h0000_BEEF, 5'd7, 1'b0);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_wr_data", cap_wr, 32'hBEEF_BEEF);
        chk("sh_we", 32'(cap_we), 32'd1);
        chk("sh_addr", cap_addr, 32'h200);

        exp_q.push_back(wbv(1'b1, 5'd8, 1'b1, 32'h301, 1'b1));
        issue("lw_mis", LW, 32'h301, 32'd0, 5'd8, 1'b0);
        chk("lw_mis_busy", 32'(busy_cnt), 32'd0);
        chk("lw_mis_req", 32'(req_cycles), 32'd0);

        // Load whose ack lands under a pipeline stall: result parks until stall drops
        rd_word = 32'hCAFE_F00D;
        exp_q.push_back(wbv(1'b1, 5'd9, 1'b0, 32'hCAFE_F00D, 1'b0));
        xstall = 1'b1;
        set_ex(LW, 32'h400, 32'd0, 5'd9, 1'b0);
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!bif.bus_ack && n < 20);
            chk("done_ack_seen", 32'(bif.bus_ack), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("done_out_held", mem_out, 32'h301);
        chk("done_busy", 32'(mem_busy), 32'd0);
        chk("done_req_clr", 32'(bif.bus_req), 32'd0);
        xstall = 1'b0;
        wait_accept("lw_done");

        exp_q.push_back(wbv(1'b1, 5'd10, 1'b0, 32'h55, 1'b0));
        issue("add2", NOP, 32'h55, 32'd0, 5'd10, 1'b0);

        // Flush during REQ: access runs to completion, result discarded
        ack_wait = 3; req_cycles = 0;
        exp_q.push_back(BUBBLE);
        set_ex(LW, 32'h500, 32'd0, 5'd11, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_req_held", 32'(bif.bus_req), 32'd1);
        wait_accept("lw_flush");
        chk("flush_req_cycles", 32'(req_cycles), 32'd4);

        ack_wait = 0;
        exp_q.push_back(wbv(1'b1, 5'd12, 1'b1, 32'h601, 1'b0));
        issue("sb", SB, 32'h601, 32'h0000_01A5, 5'd12, 1'b0);
        chk("sb_be", 32'(cap_be), 32'h2);
        chk("sb_wr_data", cap_wr, 32'hA5A5_A5A5);

        rd_word = 32'h8001_1234;
        exp_q.push_back(wbv(1'b1, 5'd13, 1'b0, 32'hFFFF_8001, 1'b0));
        issue("lh", LH, 32'h702, 32'd0, 5'd13, 1'b0);
        exp_q.push_back(wbv(1'b1, 5'd16, 1'b0, 32'h0000_1234, 1'b0));
        issue("lhu", LHU, 32'h700, 32'd0, 5'd16, 1'b0);

        // Reset mid-REQ abandons the access asynchronously
        ack_wait = 20;
        exp_q.push_back(BUBBLE);
        set_ex(LW, 32'h800, 32'd0, 5'd15, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_mid_req_before", 32'(bif.bus_req), 32'd1);
        @(posedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        chk("rst_mid_req", 32'(bif.bus_req), 32'd0);
        chk("rst_mid_be", 32'(bif.bus_be), 32'd0);
        chk("rst_mid_en", 32'(mem_en), 32'd0);
        ex_en = 1'b0; ex_mem_op = NOP; ex_out = 32'd0; ex_dst_addr = 5'd0; ex_gpr_we_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_ = 1'b1;

        exp_q.push_back(wbv(1'b1, 5'd14, 1'b0, 32'h77, 1'b0));
        issue("add3", NOP, 32'h77, 32'd0, 5'd14, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
